// File: rtl/alu_seq.sv
// alu_seq: sequential, width-parametrised ALU with valid/ready handshakes.
// SUM, SUB and illegal opcodes complete at the acceptance edge. MUL iterates
// one multiplier bit per cycle with a shift-add loop. The full 2*WIDTH-bit
// product is presented on {result_hi, result}.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             op_err
);

  // The bit counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic accept;

  // Single-cycle arithmetic, computed one bit wider so the top bit is carry/borrow.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           sum_ovf;
  logic           sub_ovf;

  // Shift-add multiplier state.
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      count_reg;
  logic               mul_last;

  // Registered result and flags, together with their next values.
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] hi_next;
  logic             zero_reg;
  logic             zero_next;
  logic             carry_reg;
  logic             carry_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             err_reg;
  logic             err_next;
  logic             out_load;

  // Handshake. in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);

  // Single-cycle operations.
  assign sum_ext  = {1'b0, data1} + {1'b0, data2};
  assign diff_ext = {1'b0, data1} - {1'b0, data2};
  // SUM overflows when the operands share a sign that the result lacks.
  assign sum_ovf  = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != data1[WIDTH-1]);
  // SUB overflows when the operand signs differ and the result sign differs from data1.
  assign sub_ovf  = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != data1[WIDTH-1]);

  // One multiply step: add the shifted multiplicand when the current multiplier bit is 1.
  assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mul_last = (count_reg == CW'(1));

  // Results are loaded at a non-MUL acceptance, or on the last multiply step.
  assign out_load = (accept && (sel != OP_MUL)) ||
                    ((state_reg == ST_MUL) && mul_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. An acceptance from DONE implies out_ready, so it also
  // retires the held result on the same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (sel == OP_MUL) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_next = (sel == OP_MUL) ? ST_MUL : ST_DONE;
        end else if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Multiplier datapath: load on a MUL acceptance, then shift one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (accept && (sel == OP_MUL)) begin
      mcand_reg  <= {{WIDTH{1'b0}}, data1};
      acc_reg    <= '0;
      mplier_reg <= data2;
      count_reg  <= CW'(WIDTH);
    end else if (state_reg == ST_MUL) begin
      acc_reg    <= acc_step;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - CW'(1);
    end
  end

  // Result and flag selection for whichever operation is completing this edge.
  always_comb begin
    result_next = '0;
    hi_next     = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    err_next    = 1'b0;
    if (state_reg == ST_MUL) begin
      result_next = acc_step[WIDTH-1:0];
      hi_next     = acc_step[2*WIDTH-1:WIDTH];
      carry_next  = (acc_step[2*WIDTH-1:WIDTH] != '0);
    end else begin
      case (sel)
        OP_SUM: begin
          result_next = sum_ext[WIDTH-1:0];
          carry_next  = sum_ext[WIDTH];
          ovf_next    = sum_ovf;
        end
        OP_SUB: begin
          result_next = diff_ext[WIDTH-1:0];
          carry_next  = diff_ext[WIDTH];
          ovf_next    = sub_ovf;
        end
        default: begin
          // Opcode 11: zero result with op_err. Opcode 10 never loads here.
          err_next = 1'b1;
        end
      endcase
    end
    zero_next = (result_next == '0);
  end

  // Output registers: hold their value until the next operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      hi_reg     <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else if (out_load) begin
      result_reg <= result_next;
      hi_reg     <= hi_next;
      zero_reg   <= zero_next;
      carry_reg  <= carry_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
    end
  end

  assign result    = result_reg;
  assign result_hi = hi_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign overflow  = ovf_reg;
  assign op_err    = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. A cycle-level transaction
// model predicts out_valid, in_ready and the result of each accepted operation
// from plain integer arithmetic. Directed cases with literal expectations pin
// the model. A randomized phase exercises handshakes and operands.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic [1:0]   sel = 2'b00;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         op_err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .overflow(overflow), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         o;
    logic         e;
  } exp_t;

  int     n_checks = 0;
  int     n_fail = 0;
  longint edge_cnt = 0;

  // Transaction model state.
  bit     mon_en = 1'b0;
  bit     pending = 1'b0;
  longint valid_edge = 0;
  exp_t   cur = '0;
  bit     m_ov;
  bit     m_ir;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the opcode definitions.
  function automatic exp_t ref_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint ua, ub, sa, sb, t, st;
    longint smax, smin;
    r    = '0;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    case (s)
      2'b00: begin
        t     = ua + ub;
        st    = sa + sb;
        r.res = W'(t);
        r.c   = (t >= (longint'(1) << W));
        r.o   = (st > smax) || (st < smin);
      end
      2'b01: begin
        t     = ua - ub;
        st    = sa - sb;
        r.res = W'(t);
        r.c   = (ua < ub);
        r.o   = (st > smax) || (st < smin);
      end
      2'b10: begin
        t     = ua * ub;
        r.res = W'(t);
        r.hi  = W'(t >> W);
        r.c   = (r.hi != '0);
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  // Compare process: checks handshake outputs every cycle, results while valid.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ov = pending && (edge_cnt >= valid_edge);
      m_ir = !pending || (m_ov && out_ready);
      chk("mon out_valid", 64'(out_valid), 64'(m_ov));
      chk("mon in_ready", 64'(in_ready), 64'(m_ir));
      if (m_ov && out_valid) begin
        chk("mon outputs", 64'({result, result_hi, zero, carry, overflow, op_err}), 64'(cur));
      end
      if (m_ov && out_ready) pending = 1'b0;
      if (in_valid && m_ir) begin
        pending    = 1'b1;
        cur        = ref_op(sel, data1, data2);
        valid_edge = edge_cnt + 1 + ((sel == 2'b10) ? longint'(W) : longint'(0));
      end
    end
  end

  // Present an operation until accepted; returns just after the acceptance edge.
  task automatic issue(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output longint acc);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    sel = s;
    data1 = a;
    data2 = b;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue: in_ready never rose, expected within %0d cycles", 4 * W);
    end
    @(posedge clk);
    #1;
    acc = edge_cnt;
    in_valid = 1'b0;
    // Scramble operands after acceptance; they must not affect the result.
    data1 = W'($urandom);
    data2 = W'($urandom);
    sel = 2'($urandom);
  endtask

  // Wait for out_valid; reports latency in edges (acceptance edge counted) and stall cycles.
  task automatic wait_valid(input longint acc, output longint lat, output int stall);
    lat = -1;
    stall = 0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = edge_cnt - acc + 1;
        break;
      end
      if (!in_ready) stall++;
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: out_valid never rose, expected within %0d cycles", 4 * W);
    end
  endtask

  task automatic run_lit(input string name, input logic [1:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e, input int exp_lat);
    longint acc, lat;
    int     stall;
    out_ready = 1'b1;
    issue(s, a, b, acc);
    wait_valid(acc, lat, stall);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " in_ready-low cycles"}, 64'(stall), 64'((s == 2'b10) ? W : 0));
    chk({name, " outputs"}, 64'({result, result_hi, zero, carry, overflow, op_err}), 64'(e));
    $display("txn %s: sel=%0d a=%h b=%h -> result=%h hi=%h z=%0d c=%0d o=%0d e=%0d lat=%0d",
             name, s, a, b, result, result_hi, zero, carry, overflow, op_err, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] corners [4];

  initial begin
    longint acc, lat;
    int     stall;
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({out_valid, result, result_hi, zero, carry, overflow, op_err}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset in_ready", 64'(in_ready), 64'(1));
    pending = 1'b0;
    mon_en  = 1'b1;

    // Directed cases with hand-computed values.
    run_lit("SUM ovf", 2'b00, 16'h7FFF, 16'h0001, exp_t'{16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 1);
    run_lit("SUM carry", 2'b00, 16'hFFFF, 16'h0001, exp_t'{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}, 1);
    run_lit("SUB borrow", 2'b01, 16'h0003, 16'h0005, exp_t'{16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}, 1);
    run_lit("SUB ovf", 2'b01, 16'h8000, 16'h0001, exp_t'{16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 1);
    run_lit("ILLEGAL", 2'b11, 16'h1234, 16'h5678, exp_t'{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}, 1);
    run_lit("MUL 300x300", 2'b10, 16'd300, 16'd300, exp_t'{16'h5F90, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0}, W + 1);
    run_lit("MUL zero", 2'b10, 16'h0000, 16'hBEEF, exp_t'{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}, W + 1);

    // Backpressure, then back-to-back handshake plus new acceptance on one edge.
    out_ready = 1'b0;
    issue(2'b00, 16'h1111, 16'h2222, acc);
    wait_valid(acc, lat, stall);
    chk("bp latency", 64'(lat), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold outputs", 64'({result, result_hi, zero, carry, overflow, op_err}),
          64'(exp_t'{16'h3333, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}));
      chk("bp hold in_ready", 64'(in_ready), 64'(0));
      chk("bp hold out_valid", 64'(out_valid), 64'(1));
    end
    $display("txn backpressure SUM: result=%h held 5 cycles", result);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    sel = 2'b01;
    data1 = 16'h0010;
    data2 = 16'h0001;
    @(negedge clk);
    chk("b2b in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data1 = W'($urandom);
    data2 = W'($urandom);
    @(negedge clk);
    chk("b2b out_valid", 64'(out_valid), 64'(1));
    chk("b2b outputs", 64'({result, result_hi, zero, carry, overflow, op_err}),
        64'(exp_t'{16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}));
    $display("txn back-to-back SUB: result=%h", result);
    @(posedge clk);
    #1;

    run_lit("MUL FFFFxFFFF", 2'b10, 16'hFFFF, 16'hFFFF, exp_t'{16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0}, W + 1);

    // Reset in the middle of a multiply.
    out_ready = 1'b1;
    issue(2'b10, 16'd1234, 16'd5678, acc);
    repeat (4) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", 64'({out_valid, result, result_hi, zero, carry, overflow, op_err}), 64'(0));
    rst_n = 1'b1;
    pending = 1'b0;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    $display("txn reset mid-MUL: outputs cleared, in_ready=%0d", in_ready);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    run_lit("post-reset SUM", 2'b00, 16'h0002, 16'h0003, exp_t'{16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}, 1);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      data1     = W'($urandom);
      data2     = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) data1 = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) data2 = corners[$urandom_range(0, 3)];
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
